// File: rtl/alu_pipe_if.sv
// Issue/writeback bundle for alu_pipe: op handshake, flush, bypass and wb entry.
// The ALU side uses the slave modport; the issue/writeback side uses master.
interface alu_pipe_if #(
  parameter int XLEN = 64,
  parameter int ROBW = 8,
  parameter int PRW  = 7
) ();
  logic            i_flush;
  logic            i_vld;
  logic            o_rdy;
  logic [4:0]      i_op;
  logic [XLEN-1:0] i_src0;
  logic [XLEN-1:0] i_src1;
  logic [ROBW-1:0] i_rob_idx;
  logic            i_rd_wen;
  logic [PRW-1:0]  i_iprd_idx;
  logic            o_willwrite_vld;
  logic [PRW-1:0]  o_willwrite_rdIdx;
  logic [XLEN-1:0] o_willwrite_data;
  logic            i_wb_stall;
  logic            o_wb_vld;
  logic [ROBW-1:0] o_wb_rob_idx;
  logic            o_wb_rd_wen;
  logic [PRW-1:0]  o_wb_iprd_idx;
  logic [XLEN-1:0] o_wb_result;

  modport master (
    output i_flush, i_vld, i_op, i_src0, i_src1, i_rob_idx, i_rd_wen, i_iprd_idx, i_wb_stall,
    input  o_rdy, o_willwrite_vld, o_willwrite_rdIdx, o_willwrite_data,
    input  o_wb_vld, o_wb_rob_idx, o_wb_rd_wen, o_wb_iprd_idx, o_wb_result
  );

  modport slave (
    input  i_flush, i_vld, i_op, i_src0, i_src1, i_rob_idx, i_rd_wen, i_iprd_idx, i_wb_stall,
    output o_rdy, o_willwrite_vld, o_willwrite_rdIdx, o_willwrite_data,
    output o_wb_vld, o_wb_rob_idx, o_wb_rd_wen, o_wb_iprd_idx, o_wb_result
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined integer ALU with valid/ready input, bubble-collapsing stall, flush and
// one-cycle-early writeback bypass. Define ALU_ZBA_EN to add sh1add/sh2add/sh3add.
module alu_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int ROBW   = 8,
  parameter int PRW    = 7
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave io
);

  localparam int SHW  = $clog2(XLEN);
  localparam int LAST = STAGES - 1;

  typedef enum logic [4:0] {
    OP_LUI  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_ADDW = 5'd3,
    OP_SUBW = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7,
    OP_SLLW = 5'd8,  OP_SRLW = 5'd9,  OP_SRAW = 5'd10, OP_XOR  = 5'd11,
    OP_OR   = 5'd12, OP_AND  = 5'd13, OP_SLT  = 5'd14, OP_SLTU = 5'd15,
    OP_SH1ADD = 5'd16, OP_SH2ADD = 5'd17, OP_SH3ADD = 5'd18
  } op_e;

  typedef struct packed {
    logic [ROBW-1:0] rob;
    logic            wen;
    logic [PRW-1:0]  prd;
    logic [XLEN-1:0] res;
  } ent_t;

  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  sh;
  logic [4:0]      shw;
  logic [31:0]     addw, subw, sllw, srlw, sraw;

  // W ops work on the low word and sign-extend; at XLEN==32 this equals the base op.
  always_comb begin
    sh      = io.i_src1[SHW-1:0];
    shw     = io.i_src1[4:0];
    addw    = io.i_src0[31:0] + io.i_src1[31:0];
    subw    = io.i_src0[31:0] - io.i_src1[31:0];
    sllw    = io.i_src0[31:0] << shw;
    srlw    = io.i_src0[31:0] >> shw;
    sraw    = $signed(io.i_src0[31:0]) >>> shw;
    alu_res = '0;
    case (io.i_op)
      OP_LUI:  alu_res = XLEN'($signed({io.i_src1[19:0], 12'b0}));
      OP_ADD:  alu_res = io.i_src0 + io.i_src1;
      OP_SUB:  alu_res = io.i_src0 - io.i_src1;
      OP_ADDW: alu_res = XLEN'($signed(addw));
      OP_SUBW: alu_res = XLEN'($signed(subw));
      OP_SLL:  alu_res = io.i_src0 << sh;
      OP_SRL:  alu_res = io.i_src0 >> sh;
      OP_SRA:  alu_res = $signed(io.i_src0) >>> sh;
      OP_SLLW: alu_res = XLEN'($signed(sllw));
      OP_SRLW: alu_res = XLEN'($signed(srlw));
      OP_SRAW: alu_res = XLEN'($signed(sraw));
      OP_XOR:  alu_res = io.i_src0 ^ io.i_src1;
      OP_OR:   alu_res = io.i_src0 | io.i_src1;
      OP_AND:  alu_res = io.i_src0 & io.i_src1;
      OP_SLT:  alu_res = XLEN'($signed(io.i_src0) < $signed(io.i_src1));
      OP_SLTU: alu_res = XLEN'(io.i_src0 < io.i_src1);
`ifdef ALU_ZBA_EN
      OP_SH1ADD: alu_res = (io.i_src0 << 1) + io.i_src1;
      OP_SH2ADD: alu_res = (io.i_src0 << 2) + io.i_src1;
      OP_SH3ADD: alu_res = (io.i_src0 << 3) + io.i_src1;
`endif
      default: alu_res = '0;
    endcase
  end

  ent_t              ent_q [STAGES];
  ent_t              ent_d [STAGES];
  ent_t              in_ent;
  logic [STAGES-1:0] vld_q, vld_d, adv;
  logic              rdy, acc;

  // adv[s]: stage s may hand its entry forward (next stage empty or itself moving).
  always_comb begin
    in_ent.rob = io.i_rob_idx;
    in_ent.wen = io.i_rd_wen;
    in_ent.prd = io.i_iprd_idx;
    in_ent.res = alu_res;
    adv        = '0;
    adv[LAST]  = !io.i_wb_stall;
    for (int unsigned k = 1; k < STAGES; k++) begin
      adv[LAST-k] = !vld_q[LAST-k+1] || adv[LAST-k+1];
    end
    rdy   = !vld_q[0] || adv[0];
    acc   = io.i_vld && rdy;
    vld_d = vld_q;
    ent_d = ent_q;
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (adv[k-1]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) ent_d[k] = ent_q[k-1];
      end
    end
    if (rdy) vld_d[0] = io.i_vld;
    if (acc) ent_d[0] = in_ent;
    if (io.i_flush) vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ent_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      ent_q <= ent_d;
    end
  end

  assign io.o_rdy         = rdy;
  assign io.o_wb_vld      = vld_q[LAST] && !io.i_flush;
  assign io.o_wb_rob_idx  = ent_q[LAST].rob;
  assign io.o_wb_rd_wen   = ent_q[LAST].wen;
  assign io.o_wb_iprd_idx = ent_q[LAST].prd;
  assign io.o_wb_result   = ent_q[LAST].res;

  // The bypass source is whatever lands in the wb stage at the next edge.
  generate
    if (STAGES >= 2) begin : g_byp
      assign io.o_willwrite_vld   = vld_q[STAGES-2] && adv[STAGES-2] && ent_q[STAGES-2].wen && !io.i_flush;
      assign io.o_willwrite_rdIdx = ent_q[STAGES-2].prd;
      assign io.o_willwrite_data  = ent_q[STAGES-2].res;
    end else begin : g_byp
      assign io.o_willwrite_vld   = acc && io.i_rd_wen && !io.i_flush;
      assign io.o_willwrite_rdIdx = io.i_iprd_idx;
      assign io.o_willwrite_data  = alu_res;
    end
  endgenerate

endmodule
